// File: rtl/div_burst_pulse_gen.sv
// Burst pulse generator fed by the /2../16 divider: turns rising edges of one selected
// divided clock into single-cycle pulses, N per burst. Optional input sync: DIV_BURST_SYNC_IN_EN.
module div_burst_pulse_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_div_2,
  input  logic             clk_div_4,
  input  logic             clk_div_8,
  input  logic             clk_div_16,
  input  logic [1:0]       sel,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a one-cycle request sampled only in IDLE; there is no ready,
  // a start seen in any other state is dropped. done is a one-cycle completion strobe.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] len_q;
  logic             hist_q;
  logic [3:0]       div_raw;
  logic [3:0]       div_lvl;
  logic             src;
  logic             rise;
  logic [CNT_W-1:0] cnt_inc;

  logic latch_en;
  logic hist_en;
  logic count_en;
  logic done_d;
  logic busy_d;

  assign div_raw = {clk_div_16, clk_div_8, clk_div_4, clk_div_2};

`ifdef DIV_BURST_SYNC_IN_EN
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= div_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign div_lvl = sync_q2;
`else
  assign div_lvl = div_raw;
`endif

  assign src       = div_lvl[sel_q];
  assign rise      = src & ~hist_q;
  assign cnt_inc   = pulse_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign state_dbg = state_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    hist_en  = 1'b0;
    count_en = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARM;
          latch_en = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ARM: begin
        // History is primed with the current level so a source already high is not an edge.
        hist_en = 1'b1;
        state_d = (len_q == '0) ? FIN : RUN;
      end
      RUN: begin
        hist_en = 1'b1;
        if (rise) begin
          count_en = 1'b1;
          if (cnt_inc == len_q) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sel_q     <= '0;
      len_q     <= '0;
      hist_q    <= 1'b0;
      pulse     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      pulse <= count_en;
      busy  <= busy_d;
      done  <= done_d;
      if (hist_en) begin
        hist_q <= src;
      end
      if (latch_en) begin
        sel_q     <= sel;
        len_q     <= burst_len;
        pulse_cnt <= '0;
      end else if (count_en) begin
        pulse_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_div_burst_pulse_gen.sv
// Bench for div_burst_pulse_gen: a counter stands in for the divider, and expected
// pulse/done/busy cycles come from closed-form edge arithmetic on that counter.
module tb_div_burst_pulse_gen;

  localparam int CNT_W = 8;
`ifdef DIV_BURST_SYNC_IN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk_in = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       div_cnt = 4'd1;
  logic             clk_div_2, clk_div_4, clk_div_8, clk_div_16;
  logic [1:0]       sel = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] burst_len = '0;
  logic             pulse, busy, done;
  logic [CNT_W-1:0] pulse_cnt;
  logic [1:0]       state_dbg;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_pulse_q[$];
  logic [31:0] obs_done_q[$];
  logic [31:0] obs_busy_q[$];
  int exp_done, exp_busy_lo, exp_busy_hi;

  div_burst_pulse_gen #(.CNT_W(CNT_W)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .clk_div_2  (clk_div_2),
    .clk_div_4  (clk_div_4),
    .clk_div_8  (clk_div_8),
    .clk_div_16 (clk_div_16),
    .sel        (sel),
    .start      (start),
    .burst_len  (burst_len),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset / divider stand-in ----------------
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  // The counter value seen at posedge number n is n mod 16.
  always @(negedge clk_in) div_cnt <= 4'(cyc + 1);
  assign clk_div_2  = div_cnt[0];
  assign clk_div_4  = div_cnt[1];
  assign clk_div_8  = div_cnt[2];
  assign clk_div_16 = div_cnt[3];

  // ---------------- reference model ----------------
  // Source period P = 2^(s+1); it rises at edges e with (e-LAT) mod P == P/2.
  // The first countable rise is at t0+2 or later (ARM primes history at t0+1).
  task automatic model_burst(input int s, input int l, input int t0);
    int p, e, fin;
    p = 2 << s;
    exp_q.delete();
    e = t0 + 2;
    while (((e - LAT) % p) != p / 2) e++;
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(32'(e));
      e += p;
    end
    fin = (l == 0) ? t0 + 1 : int'(exp_q[l-1]);
    exp_done    = fin + 1;
    exp_busy_lo = t0;
    exp_busy_hi = fin;
  endtask

  // ---------------- drivers / monitor ----------------
  task automatic start_burst(input logic [1:0] s, input logic [CNT_W-1:0] l, output int t0);
    @(negedge clk_in);
    sel       = s;
    burst_len = l;
    start     = 1'b1;
    t0        = cyc + 1;
    @(negedge clk_in);
    start     = 1'b0;
    sel       = 2'($urandom_range(0, 3));
    burst_len = CNT_W'($urandom_range(0, 255));
  endtask

  task automatic observe(input int last_cyc, input int inj_a, input int inj_b);
    obs_pulse_q.delete();
    obs_done_q.delete();
    obs_busy_q.delete();
    for (int k = 0; k < 4000; k++) begin
      if (pulse === 1'b1) obs_pulse_q.push_back(32'(cyc));
      if (done === 1'b1)  obs_done_q.push_back(32'(cyc));
      if (busy === 1'b1)  obs_busy_q.push_back(32'(cyc));
      start = (cyc == inj_a) || (cyc == inj_b);
      if (start) begin
        sel       = 2'd0;
        burst_len = 8'd1;
      end
      if (cyc >= last_cyc) break;
      @(negedge clk_in);
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if ({pulse, busy, done} !== 3'b000 || pulse_cnt !== '0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_hold: pulse=%b busy=%b done=%b cnt=%0d state=%0d want all 0",
               pulse, busy, done, pulse_cnt, state_dbg);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk_in);
    n_cmp++;
    if ({pulse, busy, done} !== 3'b000 || pulse_cnt !== '0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_idle: pulse=%b busy=%b done=%b cnt=%0d state=%0d want all 0",
               pulse, busy, done, pulse_cnt, state_dbg);
    end
  endtask

  task automatic test_bursts();
    int s_tab[12] = '{0, 3, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0};
    int l_tab[12] = '{3, 2, 0, 4, 255, 1, 0, 0, 0, 0, 0, 0};
    int t0;
    for (int b = 6; b < 12; b++) begin
      s_tab[b] = $urandom_range(0, 3);
      l_tab[b] = $urandom_range(0, 6);
    end
    for (int b = 0; b < 12; b++) begin
      start_burst(2'(s_tab[b]), CNT_W'(l_tab[b]), t0);
      model_burst(s_tab[b], l_tab[b], t0);
      observe(exp_done + 4, -1, -1);
      n_cmp++;
      if (obs_pulse_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL burst%0d pulse_count: got %0d want %0d", b, obs_pulse_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_pulse_q.size(); i++) begin
        n_cmp++;
        if (obs_pulse_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL burst%0d pulse_cyc[%0d]: got %0d want %0d", b, i, obs_pulse_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (obs_done_q.size() != 1 || obs_done_q[0] != 32'(exp_done)) begin
        n_err++;
        $display("FAIL burst%0d done: got %0d strobes first %0d want 1 at %0d", b,
                 obs_done_q.size(), (obs_done_q.size() > 0) ? int'(obs_done_q[0]) : -1, exp_done);
      end
      n_cmp++;
      if (obs_busy_q.size() != exp_busy_hi - exp_busy_lo + 1 || obs_busy_q[0] != 32'(exp_busy_lo) ||
          obs_busy_q[$] != 32'(exp_busy_hi)) begin
        n_err++;
        $display("FAIL burst%0d busy: got %0d cycles want %0d..%0d", b, obs_busy_q.size(),
                 exp_busy_lo, exp_busy_hi);
      end
      n_cmp++;
      if (pulse_cnt !== CNT_W'(l_tab[b])) begin
        n_err++;
        $display("FAIL burst%0d pulse_cnt_hold: got %0d want %0d", b, pulse_cnt, l_tab[b]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int t0;
    start_burst(2'd2, 8'd4, t0);
    model_burst(2, 4, t0);
    // Retry once mid-burst and once in the FIN cycle (the cycle of the last pulse).
    observe(exp_done + 6, int'(exp_q[0]) + 1, int'(exp_q[3]));
    n_cmp++;
    if (obs_pulse_q.size() != 4) begin
      n_err++;
      $display("FAIL ignore pulse_count: got %0d want 4", obs_pulse_q.size());
    end
    for (int i = 0; i < 4 && i < obs_pulse_q.size(); i++) begin
      n_cmp++;
      if (obs_pulse_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL ignore pulse_cyc[%0d]: got %0d want %0d", i, obs_pulse_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs_busy_q.size() != exp_busy_hi - exp_busy_lo + 1 || obs_done_q.size() != 1) begin
      n_err++;
      $display("FAIL ignore busy_done: got busy %0d done %0d want busy %0d done 1",
               obs_busy_q.size(), obs_done_q.size(), exp_busy_hi - exp_busy_lo + 1);
    end
    n_cmp++;
    if (pulse_cnt !== 8'd4) begin
      n_err++;
      $display("FAIL ignore pulse_cnt: got %0d want 4", pulse_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    start_burst(2'd1, 8'd5, t0);
    model_burst(1, 5, t0);
    observe(int'(exp_q[1]), -1, -1);
    n_cmp++;
    if (obs_pulse_q.size() != 2) begin
      n_err++;
      $display("FAIL rst_mid pre_pulses: got %0d want 2", obs_pulse_q.size());
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({pulse, busy, done} !== 3'b000 || pulse_cnt !== '0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid immediate: pulse=%b busy=%b done=%b cnt=%0d want all 0",
               pulse, busy, done, pulse_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid held%0d: done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    rst = 1'b1;
    start_burst(2'd0, 8'd2, t0);
    model_burst(0, 2, t0);
    observe(exp_done + 3, -1, -1);
    n_cmp++;
    if (obs_pulse_q.size() != 2 || obs_pulse_q[0] != exp_q[0] || obs_pulse_q[1] != exp_q[1]) begin
      n_err++;
      $display("FAIL rst_mid restart_pulses: got %0d pulses want 2 at %0d,%0d",
               obs_pulse_q.size(), exp_q[0], exp_q[1]);
    end
    n_cmp++;
    if (obs_done_q.size() != 1 || obs_done_q[0] != 32'(exp_done) || pulse_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL rst_mid restart_done: got %0d strobes cnt %0d want 1 at %0d cnt 2",
               obs_done_q.size(), pulse_cnt, exp_done);
    end
  endtask

  initial begin
    test_reset();
    test_bursts();
    test_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
